// File: rtl/axi_lite_ipif_bridge_if.sv
// rtl/axi_lite_ipif_bridge_if.sv - AXI4-Lite and IPIF bus interfaces used by axi_lite_ipif_bridge
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

interface ipif_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_CHIP = 1,
  parameter int N_REG  = 1
);
  logic [ADDR_W-1:0]       Bus2IP_Addr;
  logic                    Bus2IP_RNW;
  logic [DATA_W/8-1:0]     Bus2IP_BE;
  logic [N_CHIP-1:0]       Bus2IP_CS;
  logic [N_CHIP*N_REG-1:0] Bus2IP_RdCE;
  logic [N_CHIP*N_REG-1:0] Bus2IP_WrCE;
  logic [DATA_W-1:0]       Bus2IP_Data;
  logic [DATA_W-1:0]       IP2Bus_Data;
  logic                    IP2Bus_WrAck;
  logic                    IP2Bus_RdAck;
  logic                    IP2Bus_Error;

  modport master (
    output Bus2IP_Addr, Bus2IP_RNW, Bus2IP_BE, Bus2IP_CS, Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Data,
    input  IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Addr, Bus2IP_RNW, Bus2IP_BE, Bus2IP_CS, Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Data,
    output IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );
endinterface

// File: rtl/axi_lite_ipif_bridge.sv
// rtl/axi_lite_ipif_bridge.sv - AXI4-Lite slave to IPIF master bridge with CS/CE decode and timeout
module axi_lite_ipif_bridge #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CHIP             = 1,
  parameter int N_REG              = 1,
  parameter int TIMEOUT            = 16
) (
  input logic       S_AXI_ACLK,
  input logic       S_AXI_ARESET,
  axi_lite_if.slave s_axi,
  ipif_if.master    ipif
);
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int BW  = DW / 8;
  localparam int NCE = N_CHIP * N_REG;
  localparam int RW  = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int CW  = (N_CHIP > 1) ? $clog2(N_CHIP) : 1;
  localparam int HI  = 2 + RW + CW;
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WRESP, S_RRESP} state_t;

  typedef struct packed {
    logic              valid;
    logic [N_CHIP-1:0] cs;
    logic [NCE-1:0]    ce;
  } dec_t;

  // Chip 0 / register 0 map to the most significant CS/CE bits.
  function automatic dec_t decode(input logic [AW-1:0] addr);
    dec_t          d;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    r = addr[2 +: RW];
    c = addr[2+RW +: CW];
    d.valid = (int'(r) < N_REG) && (int'(c) < N_CHIP) && ((addr >> HI) == '0);
    for (int i = 0; i < N_CHIP; i++) begin
      d.cs[N_CHIP-1-i] = d.valid && (int'(c) == i);
      for (int j = 0; j < N_REG; j++)
        d.ce[NCE-1-N_REG*i-j] = d.valid && (int'(c) == i) && (int'(r) == j);
    end
    return d;
  endfunction

  state_t           r_state;
  logic             r_arready;
  logic             r_awready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_rvalid;
  logic [1:0]       r_rresp;
  logic [DW-1:0]    r_rdata;
  logic [AW-1:0]    r_addr;
  logic             r_rnw;
  logic [BW-1:0]    r_be;
  logic [N_CHIP-1:0] r_cs;
  logic [NCE-1:0]   r_rdce;
  logic [NCE-1:0]   r_wrce;
  logic [DW-1:0]    r_data;
  logic [TW-1:0]    r_cnt;

  dec_t w_ar_dec;
  dec_t w_aw_dec;
  logic w_want_rd;
  logic w_want_wr;

  assign w_ar_dec  = decode(s_axi.S_AXI_ARADDR);
  assign w_aw_dec  = decode(s_axi.S_AXI_AWADDR);
  assign w_want_rd = s_axi.S_AXI_ARVALID;
  assign w_want_wr = !s_axi.S_AXI_ARVALID && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;

  // Ready is armed one edge ahead so it stays a registered single-cycle pulse.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b0;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_rnw     <= 1'b1;
      r_be      <= '0;
      r_cs      <= '0;
      r_rdce    <= '0;
      r_wrce    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b0;
          r_awready <= 1'b0;
          if (r_arready && s_axi.S_AXI_ARVALID) begin
            r_addr <= s_axi.S_AXI_ARADDR;
            r_rnw  <= 1'b1;
            r_be   <= '1;
            if (w_ar_dec.valid) begin
              r_cs    <= w_ar_dec.cs;
              r_rdce  <= w_ar_dec.ce;
              r_cnt   <= '0;
              r_state <= S_RD;
            end else begin
              r_rresp  <= 2'b10;
              r_rdata  <= '0;
              r_rvalid <= 1'b1;
              r_state  <= S_RRESP;
            end
          end else if (r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
            r_addr <= s_axi.S_AXI_AWADDR;
            r_rnw  <= 1'b0;
            r_be   <= s_axi.S_AXI_WSTRB;
            r_data <= s_axi.S_AXI_WDATA;
            if (w_aw_dec.valid) begin
              r_cs    <= w_aw_dec.cs;
              r_wrce  <= w_aw_dec.ce;
              r_cnt   <= '0;
              r_state <= S_WR;
            end else begin
              r_bresp  <= 2'b10;
              r_bvalid <= 1'b1;
              r_state  <= S_WRESP;
            end
          end else if (!r_arready && !r_awready) begin
            r_arready <= w_want_rd;
            r_awready <= w_want_wr;
          end
        end
        S_WR: begin
          if (ipif.IP2Bus_WrAck || (r_cnt == CNT_MAX)) begin
            r_cs     <= '0;
            r_wrce   <= '0;
            r_bresp  <= (ipif.IP2Bus_WrAck && !ipif.IP2Bus_Error) ? 2'b00 : 2'b10;
            r_bvalid <= 1'b1;
            r_state  <= S_WRESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD: begin
          if (ipif.IP2Bus_RdAck || (r_cnt == CNT_MAX)) begin
            r_cs     <= '0;
            r_rdce   <= '0;
            r_rresp  <= (ipif.IP2Bus_RdAck && !ipif.IP2Bus_Error) ? 2'b00 : 2'b10;
            r_rdata  <= ipif.IP2Bus_RdAck ? ipif.IP2Bus_Data : '0;
            r_rvalid <= 1'b1;
            r_state  <= S_RRESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRESP: begin
          if (s_axi.S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_arready <= w_want_rd;
            r_awready <= w_want_wr;
            r_state   <= S_IDLE;
          end
        end
        S_RRESP: begin
          if (s_axi.S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= w_want_rd;
            r_awready <= w_want_wr;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_awready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign s_axi.S_AXI_RDATA   = r_rdata;

  assign ipif.Bus2IP_Addr = r_addr;
  assign ipif.Bus2IP_RNW  = r_rnw;
  assign ipif.Bus2IP_BE   = r_be;
  assign ipif.Bus2IP_CS   = r_cs;
  assign ipif.Bus2IP_RdCE = r_rdce;
  assign ipif.Bus2IP_WrCE = r_wrce;
  assign ipif.Bus2IP_Data = r_data;
endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// tb/tb_axi_lite_ipif_bridge.sv - self-checking bench for axi_lite_ipif_bridge (2 chips x 4 regs)
module tb_axi_lite_ipif_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int RSPAN = (NR > 1) ? (1 << $clog2(NR)) : 2;
  localparam int CSPAN = (NC > 1) ? (1 << $clog2(NC)) : 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();
  ipif_if #(.ADDR_W(AW), .DATA_W(DW), .N_CHIP(NC), .N_REG(NR)) ip ();

  axi_lite_ipif_bridge #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW),
    .N_CHIP(NC), .N_REG(NR), .TIMEOUT(TO)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .s_axi(axi),
    .ipif(ip)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IP slave: acks on the ack_k-th consecutive CS cycle (0 = never acks)
  int           ack_k = 1;
  bit           ack_err = 1'b0;
  logic [31:0]  ack_data = 32'h0;
  bit           force_wrack = 1'b0;
  int           cs_seen = 0;

  initial begin
    ip.IP2Bus_WrAck = 1'b0;
    ip.IP2Bus_RdAck = 1'b0;
    ip.IP2Bus_Error = 1'b0;
    ip.IP2Bus_Data  = '0;
    forever begin
      bit hit;
      @(posedge clk);
      #2;
      if (ip.Bus2IP_CS != '0) cs_seen++; else cs_seen = 0;
      hit = (ack_k != 0) && (cs_seen == ack_k);
      ip.IP2Bus_WrAck = (hit && !ip.Bus2IP_RNW) || force_wrack;
      ip.IP2Bus_RdAck = hit && ip.Bus2IP_RNW;
      ip.IP2Bus_Error = hit && ack_err;
      ip.IP2Bus_Data  = hit ? ack_data : 32'hBAD0BAD0;
    end
  end

  // Transaction-level reference: phase 0 idle, 1 IP access, 2 response pending
  int          m_phase = 0;
  int          m_arm = 0;
  int          m_cs_cycles = 0;
  bit          m_rd = 1'b0;
  bit          m_pristine = 1'b1;
  bit          m_started = 1'b0;
  logic [NC-1:0]    m_cs;
  logic [NC*NR-1:0] m_ce;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_be;
  logic [1:0]  m_resp;

  function automatic int choose_arm();
    if (axi.S_AXI_ARVALID) return 1;
    if (axi.S_AXI_AWVALID && axi.S_AXI_WVALID) return 2;
    return 0;
  endfunction

  task automatic model_decode(input logic [31:0] a, output bit v,
                              output logic [NC-1:0] cs, output logic [NC*NR-1:0] ce);
    int unsigned w, r, c, hi;
    w  = a / 4;
    r  = w % RSPAN;
    c  = (w / RSPAN) % CSPAN;
    hi = w / (RSPAN * CSPAN);
    v  = (hi == 0) && (r < NR) && (c < NC);
    cs = '0;
    ce = '0;
    if (v) begin
      cs = 1 << (NC - 1 - c);
      ce = 1 << (NC * NR - 1 - NR * c - r);
    end
  endtask

  task automatic model_start(input bit rd, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
    bit v;
    m_pristine = 1'b0;
    m_rd   = rd;
    m_addr = a;
    m_be   = be;
    m_data = d;
    model_decode(a, v, m_cs, m_ce);
    if (v) begin
      m_phase = 1;
      m_cs_cycles = 1;
    end else begin
      m_phase = 2;
      m_resp  = 2'b10;
      m_rdata = '0;
    end
  endtask

  always @(posedge clk) begin
    m_started = 1'b1;
    if (rst) begin
      m_phase = 0;
      m_arm = 0;
      m_pristine = 1'b1;
    end else if (m_phase == 0) begin
      if (m_arm == 1) model_start(1'b1, axi.S_AXI_ARADDR, 4'hF, m_data);
      else if (m_arm == 2) model_start(1'b0, axi.S_AXI_AWADDR, axi.S_AXI_WSTRB, axi.S_AXI_WDATA);
      m_arm = (m_arm == 0) ? choose_arm() : 0;
    end else if (m_phase == 1) begin
      if (m_rd ? ip.IP2Bus_RdAck : ip.IP2Bus_WrAck) begin
        m_phase = 2;
        m_resp  = ip.IP2Bus_Error ? 2'b10 : 2'b00;
        m_rdata = m_rd ? ip.IP2Bus_Data : 32'h0;
      end else if (m_cs_cycles == TO) begin
        m_phase = 2;
        m_resp  = 2'b10;
        m_rdata = '0;
      end else begin
        m_cs_cycles++;
      end
    end else if (m_rd ? axi.S_AXI_RREADY : axi.S_AXI_BREADY) begin
      m_phase = 0;
      m_arm = choose_arm();
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("arready", axi.S_AXI_ARREADY, (m_phase == 0 && m_arm == 1));
      chk("awready", axi.S_AXI_AWREADY, (m_phase == 0 && m_arm == 2));
      chk("wready",  axi.S_AXI_WREADY,  (m_phase == 0 && m_arm == 2));
      chk("bvalid",  axi.S_AXI_BVALID,  (m_phase == 2 && !m_rd));
      chk("rvalid",  axi.S_AXI_RVALID,  (m_phase == 2 && m_rd));
      if (m_phase == 2 && !m_rd) chk("bresp", axi.S_AXI_BRESP, m_resp);
      if (m_phase == 2 && m_rd) begin
        chk("rresp", axi.S_AXI_RRESP, m_resp);
        chk("rdata", axi.S_AXI_RDATA, m_rdata);
      end
      chk("cs",   ip.Bus2IP_CS,   (m_phase == 1) ? m_cs : '0);
      chk("rdce", ip.Bus2IP_RdCE, (m_phase == 1 && m_rd) ? m_ce : '0);
      chk("wrce", ip.Bus2IP_WrCE, (m_phase == 1 && !m_rd) ? m_ce : '0);
      if (m_phase == 1) begin
        chk("addr", ip.Bus2IP_Addr, m_addr);
        chk("rnw",  ip.Bus2IP_RNW,  m_rd);
        chk("be",   ip.Bus2IP_BE,   m_be);
        if (!m_rd) chk("wdata", ip.Bus2IP_Data, m_data);
      end
      if (m_pristine) begin
        chk("rst_addr",  ip.Bus2IP_Addr, 0);
        chk("rst_be",    ip.Bus2IP_BE, 0);
        chk("rst_data",  ip.Bus2IP_Data, 0);
        chk("rst_rnw",   ip.Bus2IP_RNW, 1);
        chk("rst_bresp", axi.S_AXI_BRESP, 0);
        chk("rst_rresp", axi.S_AXI_RRESP, 0);
        chk("rst_rdata", axi.S_AXI_RDATA, 0);
      end
    end
  end

  task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output int cs_cyc, output int lat,
                         output logic [1:0] resp, output logic [31:0] rd_data,
                         output logic [1:0] cs_first, output logic [7:0] ce_first);
    int n;
    if (rd) begin
      axi.S_AXI_ARADDR  = addr;
      axi.S_AXI_ARVALID = 1'b1;
    end else begin
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_WDATA   = wd;
      axi.S_AXI_WSTRB   = strb;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
    end
    n = 0;
    while (!(rd ? axi.S_AXI_ARREADY : axi.S_AXI_AWREADY) && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", rd ? axi.S_AXI_ARREADY : axi.S_AXI_AWREADY, 1);
    tick();
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    lat = 1;
    cs_cyc = 0;
    cs_first = '0;
    ce_first = '0;
    n = 0;
    while (!(rd ? axi.S_AXI_RVALID : axi.S_AXI_BVALID) && n < 100) begin
      if (ip.Bus2IP_CS != '0) begin
        if (cs_cyc == 0) begin
          cs_first = ip.Bus2IP_CS;
          ce_first = rd ? ip.Bus2IP_RdCE : ip.Bus2IP_WrCE;
        end
        cs_cyc++;
      end
      tick();
      lat++;
      n++;
    end
    chk("resp_valid", rd ? axi.S_AXI_RVALID : axi.S_AXI_BVALID, 1);
    resp    = rd ? axi.S_AXI_RRESP : axi.S_AXI_BRESP;
    rd_data = axi.S_AXI_RDATA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cyc, lat, n;
    bit seen;
    logic [1:0]  resp, cs_f;
    logic [31:0] rdat;
    logic [7:0]  ce_f;

    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b1;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b1;

    repeat (3) tick();
    chk("reset_arready", axi.S_AXI_ARREADY, 0);
    chk("reset_bvalid", axi.S_AXI_BVALID, 0);
    chk("reset_rvalid", axi.S_AXI_RVALID, 0);
    chk("reset_cs", ip.Bus2IP_CS, 0);
    chk("reset_rnw", ip.Bus2IP_RNW, 1);
    rst = 1'b0;
    repeat (2) tick();

    ack_k = 3; ack_err = 1'b0;
    run_txn(1'b0, 32'h14, 32'hDEADBEEF, 4'hF, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("wr_cs", cs_f, 2'b01);
    chk("wr_wrce", ce_f, 8'b00000100);
    chk("wr_cs_cycles", cs_cyc, 3);
    chk("wr_latency", lat, 4);
    chk("wr_bresp", resp, 2'b00);
    tick();

    ack_k = 1; ack_data = 32'h1234;
    run_txn(1'b1, 32'h08, 32'h0, 4'h0, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("rd_cs", cs_f, 2'b10);
    chk("rd_rdce", ce_f, 8'b00100000);
    chk("rd_latency", lat, 2);
    chk("rd_rdata", rdat, 32'h1234);
    chk("rd_rresp", resp, 2'b00);
    tick();

    ack_k = 0;
    run_txn(1'b0, 32'h04, 32'hA5A5A5A5, 4'h3, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("to_cs_cycles", cs_cyc, 16);
    chk("to_bresp", resp, 2'b10);
    tick();
    force_wrack = 1'b1;
    tick();
    force_wrack = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (axi.S_AXI_BVALID || ip.Bus2IP_CS != '0) seen = 1'b1;
    end
    chk("late_ack_ignored", seen, 0);

    ack_k = 1;
    run_txn(1'b1, 32'h40, 32'h0, 4'h0, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("dec_cs_cycles", cs_cyc, 0);
    chk("dec_rresp", resp, 2'b10);
    chk("dec_rdata", rdat, 32'h0);
    tick();

    ack_k = 2; ack_err = 1'b1;
    run_txn(1'b0, 32'h1C, 32'h0BADF00D, 4'h8, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("err_cs_cycles", cs_cyc, 2);
    chk("err_bresp", resp, 2'b10);
    ack_err = 1'b0;
    tick();

    axi.S_AXI_AWADDR  = 32'h10;
    axi.S_AXI_AWVALID = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (axi.S_AXI_AWREADY || axi.S_AXI_WREADY) seen = 1'b1;
    end
    chk("aw_without_w", seen, 0);
    axi.S_AXI_AWVALID = 1'b0;
    tick();

    ack_k = 1; ack_data = 32'h55AA;
    axi.S_AXI_RREADY  = 1'b0;
    axi.S_AXI_ARADDR  = 32'h0C;
    axi.S_AXI_AWADDR  = 32'h10;
    axi.S_AXI_WDATA   = 32'hCAFE0001;
    axi.S_AXI_WSTRB   = 4'h3;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!axi.S_AXI_ARREADY && n < 20) begin tick(); n++; end
    chk("bp_read_first", axi.S_AXI_ARREADY, 1);
    chk("bp_no_awready", axi.S_AXI_AWREADY, 0);
    tick();
    axi.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!axi.S_AXI_RVALID && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid_hold", axi.S_AXI_RVALID, 1);
      chk("bp_rdata_hold", axi.S_AXI_RDATA, 32'h55AA);
      chk("bp_awready_wait", axi.S_AXI_AWREADY, 0);
      tick();
    end
    axi.S_AXI_RREADY = 1'b1;
    tick();
    chk("bp_rvalid_done", axi.S_AXI_RVALID, 0);
    chk("bp_wr_next_awready", axi.S_AXI_AWREADY, 1);
    chk("bp_wr_next_wready", axi.S_AXI_WREADY, 1);
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 40) begin tick(); n++; end
    chk("bp_wr_bresp", axi.S_AXI_BRESP, 2'b00);
    tick();

    ack_k = 0;
    axi.S_AXI_AWADDR  = 32'h18;
    axi.S_AXI_WDATA   = 32'h11223344;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!axi.S_AXI_AWREADY && n < 20) begin tick(); n++; end
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    tick();
    chk("mid_rst_in_wr", ip.Bus2IP_CS, 2'b01);
    rst = 1'b1;
    tick();
    chk("mid_rst_cs", ip.Bus2IP_CS, 0);
    chk("mid_rst_wrce", ip.Bus2IP_WrCE, 0);
    chk("mid_rst_rnw", ip.Bus2IP_RNW, 1);
    chk("mid_rst_data", ip.Bus2IP_Data, 0);
    chk("mid_rst_bvalid", axi.S_AXI_BVALID, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (axi.S_AXI_BVALID) seen = 1'b1;
    end
    chk("mid_rst_no_bvalid", seen, 0);
    ack_k = 2;
    run_txn(1'b0, 32'h18, 32'h55667788, 4'hF, cs_cyc, lat, resp, rdat, cs_f, ce_f);
    chk("post_rst_cs", cs_f, 2'b01);
    chk("post_rst_wrce", ce_f, 8'b00000010);
    chk("post_rst_cs_cycles", cs_cyc, 2);
    chk("post_rst_bresp", resp, 2'b00);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
